// File: rtl/cs3220_pkg.sv
// Shared field widths and bubble encoding for the decode/register-read/execute slots.
package cs3220_pkg;

    localparam int OP_W    = 6;
    localparam int ALTOP_W = 8;

    typedef logic [OP_W-1:0]    op_t;
    typedef logic [ALTOP_W-1:0] altop_t;

    // A bubble in any slot is encoded as opcode 0.
    localparam op_t    OP_BUBBLE    = '0;
    localparam altop_t ALTOP_BUBBLE = '0;

endpackage

// File: rtl/rr_operand_mux.sv
// Resolves one source operand: youngest matching producer wins, else regfile data.
module rr_operand_mux #(
    parameter int XLEN    = 32,
    parameter int AW      = 4,
    parameter int NBYP    = 2,
    parameter int R0_ZERO = 1
) (
    input  logic [AW-1:0]        idx,
    input  logic                 use_op,
    input  logic [XLEN-1:0]      rf_val,
    input  logic [NBYP-1:0]      byp_valid,
    input  logic [NBYP-1:0]      byp_ready,
    input  logic [NBYP*AW-1:0]   byp_rd,
    input  logic [NBYP*XLEN-1:0] byp_val,
    output logic [XLEN-1:0]      val,
    output logic                 hazard
);

    logic is_r0;
    logic found;

    assign is_r0 = (R0_ZERO != 0) && (idx == '0);

    always_comb begin
        val    = rf_val;
        hazard = 1'b0;
        found  = 1'b0;
        if (is_r0) begin
            val = '0;
        end else begin
            // Index 0 is the youngest producer, so the first hit in ascending order wins.
            for (int k = 0; k < NBYP; k++) begin
                if (!found && byp_valid[k] && (byp_rd[k*AW +: AW] == idx)) begin
                    found  = 1'b1;
                    val    = byp_val[k*XLEN +: XLEN];
                    hazard = use_op && !byp_ready[k];
                end
            end
        end
    end

endmodule

// File: rtl/rr_bypass_stage.sv
// Register-read stage: forwards from downstream producers, bubbles on not-ready
// producers, and registers resolved operands for execute.
module rr_bypass_stage
    import cs3220_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREGS   = 16,
    parameter int NBYP    = 2,
    parameter int R0_ZERO = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 decode_valid,
    input  logic [XLEN-1:0]      decode_pc,
    input  op_t                  decode_op,
    input  altop_t               decode_altop,
    input  logic [AW-1:0]        decode_rd,
    input  logic [AW-1:0]        decode_rs,
    input  logic [AW-1:0]        decode_rt,
    input  logic                 decode_use_rs,
    input  logic                 decode_use_rt,
    input  logic [XLEN-1:0]      decode_imm32,
    output logic [AW-1:0]        dprf_ra,
    output logic [AW-1:0]        dprf_rb,
    input  logic [XLEN-1:0]      dprf_ra_val,
    input  logic [XLEN-1:0]      dprf_rb_val,
    input  logic [NBYP-1:0]      byp_valid,
    input  logic [NBYP-1:0]      byp_ready,
    input  logic [NBYP*AW-1:0]   byp_rd,
    input  logic [NBYP*XLEN-1:0] byp_val,
    output logic                 rr_valid,
    output logic [XLEN-1:0]      rr_pc,
    output op_t                  rr_op,
    output altop_t               rr_altop,
    output logic [AW-1:0]        rr_rd,
    output logic [XLEN-1:0]      rr_imm32,
    output logic [XLEN-1:0]      rr_rs_val,
    output logic [XLEN-1:0]      rr_rt_val,
    input  logic                 exec_stall,
    input  logic                 exec_flush,
    output logic                 rr_stall,
    output logic                 rr_flush,
    output logic [31:0]          hz_count
);

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [XLEN-1:0] rs_val_p0;
    logic [XLEN-1:0] rt_val_p0;
    logic            rs_hz_p0;
    logic            rt_hz_p0;
    logic            hz_p0;

    assign dprf_ra = decode_rs;
    assign dprf_rb = decode_rt;

    rr_operand_mux #(.XLEN(XLEN), .AW(AW), .NBYP(NBYP), .R0_ZERO(R0_ZERO)) u_rs_mux (
        .idx       (decode_rs),
        .use_op    (decode_use_rs),
        .rf_val    (dprf_ra_val),
        .byp_valid (byp_valid),
        .byp_ready (byp_ready),
        .byp_rd    (byp_rd),
        .byp_val   (byp_val),
        .val       (rs_val_p0),
        .hazard    (rs_hz_p0)
    );

    rr_operand_mux #(.XLEN(XLEN), .AW(AW), .NBYP(NBYP), .R0_ZERO(R0_ZERO)) u_rt_mux (
        .idx       (decode_rt),
        .use_op    (decode_use_rt),
        .rf_val    (dprf_rb_val),
        .byp_valid (byp_valid),
        .byp_ready (byp_ready),
        .byp_rd    (byp_rd),
        .byp_val   (byp_val),
        .val       (rt_val_p0),
        .hazard    (rt_hz_p0)
    );

    assign hz_p0    = decode_valid && (rs_hz_p0 || rt_hz_p0) && !exec_flush;
    assign rr_stall = exec_stall || hz_p0;
    assign rr_flush = exec_flush;

    // p0 -> p1: decode slot captured into the execute slot
    always_ff @(posedge i_clk) begin
        if (i_reset || exec_flush) begin
            rr_valid  <= 1'b0;
            rr_pc     <= '0;
            rr_op     <= OP_BUBBLE;
            rr_altop  <= ALTOP_BUBBLE;
            rr_rd     <= '0;
            rr_imm32  <= '0;
            rr_rs_val <= '0;
            rr_rt_val <= '0;
        end else if (exec_stall) begin
            rr_valid <= rr_valid;
        end else if (hz_p0) begin
            rr_valid <= 1'b0;
        end else begin
            rr_valid  <= decode_valid;
            rr_pc     <= decode_pc;
            rr_op     <= decode_op;
            rr_altop  <= decode_altop;
            rr_rd     <= decode_rd;
            rr_imm32  <= decode_imm32;
            rr_rs_val <= rs_val_p0;
            rr_rt_val <= rt_val_p0;
        end
    end

    // Bubble counter survives flushes; only reset clears it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hz_count <= '0;
        end else if (hz_p0 && !exec_stall) begin
            hz_count <= sat_inc32(hz_count);
        end
    end

endmodule

// File: tb/tb_rr_bypass_stage.sv
// Randomised and directed bench for rr_bypass_stage against a behavioural model.
module tb_rr_bypass_stage;
    import cs3220_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int NBYP  = 2;
    localparam int AW    = 4;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              decode_valid;
    logic [XLEN-1:0]   decode_pc;
    op_t               decode_op;
    altop_t            decode_altop;
    logic [AW-1:0]     decode_rd, decode_rs, decode_rt;
    logic              decode_use_rs, decode_use_rt;
    logic [XLEN-1:0]   decode_imm32;
    logic [AW-1:0]     dprf_ra, dprf_rb;
    logic [XLEN-1:0]   dprf_ra_val, dprf_rb_val;
    logic [NBYP-1:0]   byp_valid, byp_ready;
    logic [NBYP*AW-1:0]   byp_rd;
    logic [NBYP*XLEN-1:0] byp_val;
    logic              rr_valid;
    logic [XLEN-1:0]   rr_pc;
    op_t               rr_op;
    altop_t            rr_altop;
    logic [AW-1:0]     rr_rd;
    logic [XLEN-1:0]   rr_imm32, rr_rs_val, rr_rt_val;
    logic              exec_stall, exec_flush;
    logic              rr_stall, rr_flush;
    logic [31:0]       hz_count;

    // Bench-side views: register file and per-producer bypass slots.
    logic [XLEN-1:0] rf [NREGS];
    logic            bv   [NBYP];
    logic            brdy [NBYP];
    logic [AW-1:0]   brd  [NBYP];
    logic [XLEN-1:0] bval [NBYP];

    int n_checks = 0;
    int n_errors = 0;

    // Model of the execute slot
    logic            m_valid;
    logic [XLEN-1:0] m_pc, m_imm, m_rs, m_rt;
    logic [5:0]      m_op;
    logic [7:0]      m_altop;
    logic [AW-1:0]   m_rd;
    logic [31:0]     m_cnt;

    always #5 i_clk = ~i_clk;

    assign dprf_ra_val = rf[dprf_ra];
    assign dprf_rb_val = rf[dprf_rb];

    always_comb begin
        for (int k = 0; k < NBYP; k++) begin
            byp_valid[k]            = bv[k];
            byp_ready[k]            = brdy[k];
            byp_rd[k*AW +: AW]      = brd[k];
            byp_val[k*XLEN +: XLEN] = bval[k];
        end
    end

    rr_bypass_stage #(.XLEN(XLEN), .NREGS(NREGS), .NBYP(NBYP), .R0_ZERO(1)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .decode_valid(decode_valid), .decode_pc(decode_pc), .decode_op(decode_op),
        .decode_altop(decode_altop), .decode_rd(decode_rd), .decode_rs(decode_rs),
        .decode_rt(decode_rt), .decode_use_rs(decode_use_rs), .decode_use_rt(decode_use_rt),
        .decode_imm32(decode_imm32), .dprf_ra(dprf_ra), .dprf_rb(dprf_rb),
        .dprf_ra_val(dprf_ra_val), .dprf_rb_val(dprf_rb_val),
        .byp_valid(byp_valid), .byp_ready(byp_ready), .byp_rd(byp_rd), .byp_val(byp_val),
        .rr_valid(rr_valid), .rr_pc(rr_pc), .rr_op(rr_op), .rr_altop(rr_altop),
        .rr_rd(rr_rd), .rr_imm32(rr_imm32), .rr_rs_val(rr_rs_val), .rr_rt_val(rr_rt_val),
        .exec_stall(exec_stall), .exec_flush(exec_flush),
        .rr_stall(rr_stall), .rr_flush(rr_flush), .hz_count(hz_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Operand value and hazard straight from the forwarding rules.
    function automatic void resolve(input logic [AW-1:0] idx, input logic use_o,
                                    output logic [XLEN-1:0] v, output logic h);
        v = rf[idx];
        h = 1'b0;
        if (idx == 0) begin
            v = '0;
            return;
        end
        for (int k = 0; k < NBYP; k++) begin
            if (bv[k] && brd[k] == idx) begin
                v = bval[k];
                h = use_o && !brdy[k];
                return;
            end
        end
    endfunction

    // Inputs must be stable from the call until the following posedge.
    task automatic step();
        logic [XLEN-1:0] vs, vt;
        logic hs, ht, hz;
        #1;
        resolve(decode_rs, decode_use_rs, vs, hs);
        resolve(decode_rt, decode_use_rt, vt, ht);
        hz = decode_valid && (hs || ht) && !exec_flush;
        chk("rr_stall", 32'(rr_stall), 32'(exec_stall || hz));
        chk("rr_flush", 32'(rr_flush), 32'(exec_flush));
        chk("dprf_ra", 32'(dprf_ra), 32'(decode_rs));
        chk("dprf_rb", 32'(dprf_rb), 32'(decode_rt));
        @(posedge i_clk);
        if (i_reset) m_cnt = 0;
        else if (hz && !exec_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (i_reset || exec_flush) begin
            m_valid = 0; m_pc = 0; m_op = 0; m_altop = 0; m_rd = 0;
            m_imm = 0; m_rs = 0; m_rt = 0;
        end else if (exec_stall) begin
            m_valid = m_valid;
        end else if (hz) begin
            m_valid = 0;
        end else begin
            m_valid = decode_valid; m_pc = decode_pc; m_op = decode_op;
            m_altop = decode_altop; m_rd = decode_rd; m_imm = decode_imm32;
            m_rs = vs; m_rt = vt;
        end
        @(negedge i_clk);
        chk("rr_valid", 32'(rr_valid), 32'(m_valid));
        chk("rr_pc", rr_pc, m_pc);
        chk("rr_op", 32'(rr_op), 32'(m_op));
        chk("rr_altop", 32'(rr_altop), 32'(m_altop));
        chk("rr_rd", 32'(rr_rd), 32'(m_rd));
        chk("rr_imm32", rr_imm32, m_imm);
        chk("rr_rs_val", rr_rs_val, m_rs);
        chk("rr_rt_val", rr_rt_val, m_rt);
        chk("hz_count", hz_count, m_cnt);
    endtask

    task automatic clear_inputs();
        i_reset = 0; exec_stall = 0; exec_flush = 0;
        decode_valid = 0; decode_pc = 0; decode_op = 0; decode_altop = 0;
        decode_rd = 0; decode_rs = 0; decode_rt = 0;
        decode_use_rs = 0; decode_use_rt = 0; decode_imm32 = 0;
        for (int k = 0; k < NBYP; k++) begin
            bv[k] = 0; brdy[k] = 0; brd[k] = 0; bval[k] = 0;
        end
    endtask

    task automatic set_decode(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                              input logic urs, input logic urt, input logic [XLEN-1:0] pc);
        decode_valid = 1; decode_rs = rs; decode_rt = rt;
        decode_use_rs = urs; decode_use_rt = urt; decode_pc = pc;
        decode_op = 6'h21; decode_altop = 8'h5A; decode_rd = 4'd7; decode_imm32 = pc ^ 32'hFFFF;
    endtask

    initial begin
        m_valid = 0; m_pc = 0; m_op = 0; m_altop = 0; m_rd = 0;
        m_imm = 0; m_rs = 0; m_rt = 0; m_cnt = 0;
        for (int r = 0; r < NREGS; r++) rf[r] = 32'h100 * r + 32'h3;
        clear_inputs();
        i_reset = 1;
        @(negedge i_clk);
        step();
        step();
        chk("reset_valid", 32'(rr_valid), 32'd0);
        chk("reset_hzcnt", hz_count, 32'd0);

        // No hazard: plain regfile reads
        clear_inputs();
        rf[3] = 32'h11; rf[4] = 32'h22;
        set_decode(4'd3, 4'd4, 1, 1, 32'h1000);
        step();
        chk("nohz_rs", rr_rs_val, 32'h11);
        chk("nohz_rt", rr_rt_val, 32'h22);
        chk("nohz_valid", 32'(rr_valid), 32'd1);

        // Youngest producer wins
        bv[0] = 1; brd[0] = 4'd3; bval[0] = 32'hA; brdy[0] = 1;
        bv[1] = 1; brd[1] = 4'd3; bval[1] = 32'hB; brdy[1] = 1;
        set_decode(4'd3, 4'd3, 1, 1, 32'h1004);
        step();
        chk("prio_rs", rr_rs_val, 32'hA);
        chk("prio_rt", rr_rt_val, 32'hA);

        // Load-use bubble, then release when ready
        clear_inputs();
        bv[0] = 1; brd[0] = 4'd5; brdy[0] = 0; bval[0] = 32'h0;
        set_decode(4'd5, 4'd4, 1, 1, 32'h1008);
        #1 chk("lu_stall", 32'(rr_stall), 32'd1);
        step();
        chk("lu_valid", 32'(rr_valid), 32'd0);
        chk("lu_hzcnt", hz_count, 32'd1);
        brdy[0] = 1; bval[0] = 32'h77;
        step();
        chk("lu_fwd", rr_rs_val, 32'h77);
        chk("lu_valid2", 32'(rr_valid), 32'd1);
        brdy[0] = 0;
        decode_use_rs = 0;
        #1 chk("lu_unused_stall", 32'(rr_stall), 32'd0);
        step();

        // R0 reads as zero and never hazards
        clear_inputs();
        bv[0] = 1; brd[0] = 4'd0; brdy[0] = 0; bval[0] = 32'h5;
        set_decode(4'd0, 4'd4, 1, 1, 32'h100C);
        #1 chk("r0_stall", 32'(rr_stall), 32'd0);
        step();
        chk("r0_val", rr_rs_val, 32'd0);

        // Downstream stall holds for three cycles
        clear_inputs();
        set_decode(4'd3, 4'd4, 1, 1, 32'h2000);
        step();
        exec_stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_decode(4'd4, 4'd3, 1, 1, 32'h3000 + 32'(i));
            step();
        end
        chk("stall_pc", rr_pc, 32'h2000);
        chk("stall_valid", 32'(rr_valid), 32'd1);

        // Flush with a concurrent hazard: cleared, bubble not counted
        clear_inputs();
        bv[0] = 1; brd[0] = 4'd5; brdy[0] = 0;
        set_decode(4'd5, 4'd4, 1, 1, 32'h4000);
        exec_flush = 1;
        step();
        chk("flush_valid", 32'(rr_valid), 32'd0);
        chk("flush_pc", rr_pc, 32'd0);
        chk("flush_hzcnt", hz_count, 32'd1);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            i_reset      = ($urandom % 250) == 0;
            exec_stall   = ($urandom % 6) == 0;
            exec_flush   = ($urandom % 20) == 0;
            decode_valid = ($urandom % 4) != 0;
            decode_pc    = $urandom;
            decode_op    = 6'($urandom);
            decode_altop = 8'($urandom);
            decode_rd    = 4'($urandom_range(0, 15));
            decode_rs    = 4'($urandom_range(0, 5));
            decode_rt    = 4'($urandom_range(0, 5));
            decode_use_rs = 1'($urandom);
            decode_use_rt = 1'($urandom);
            decode_imm32 = $urandom;
            for (int k = 0; k < NBYP; k++) begin
                bv[k]   = 1'($urandom);
                brdy[k] = ($urandom % 3) != 0;
                brd[k]  = 4'($urandom_range(0, 5));
                bval[k] = $urandom;
            end
            rf[$urandom_range(0, NREGS - 1)] = $urandom;
            step();
        end

        // Reset in the middle of a stalled hazard
        clear_inputs();
        i_reset = 1;
        step();
        i_reset = 0;
        bv[0] = 1; brd[0] = 4'd5; brdy[0] = 0;
        set_decode(4'd5, 4'd6, 1, 0, 32'h5000);
        for (int i = 0; i < 7; i++) step();
        chk("pre_rst_hzcnt", hz_count, 32'd7);
        exec_stall = 1;
        step();
        chk("stall_hz_nocount", hz_count, 32'd7);
        i_reset = 1;
        step();
        chk("rst_hzcnt", hz_count, 32'd0);
        chk("rst_valid", 32'(rr_valid), 32'd0);
        chk("rst_pc", rr_pc, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_bypass_stage.md
# rr_bypass_stage

Parametrised register-read stage sitting between decode and execute. It reads two source operands from the register file and resolves RAW hazards by forwarding from a configurable number of downstream producers. It detects not-yet-ready producers, inserts a bubble and stalls decode, and registers the operand values so execute sees fully resolved data. A valid bit marks bubbles; downstream stall and flush are honoured.

## Interface
Parameters:
- XLEN, 32, data width
- NREGS, 16, architectural register count; AW = $clog2(NREGS)
- NBYP, 2, forwarding sources; index 0 is youngest (execute), NBYP-1 oldest (writeback)
- R0_ZERO, 1, when 1 register 0 reads as 0 and is never forwarded or hazarded

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- decode_valid  in  1  decode slot holds an instruction
- decode_pc  in  XLEN  PC
- decode_op  in  6  opcode
- decode_altop  in  8  secondary opcode
- decode_rd, decode_rs, decode_rt  in  AW  register indices
- decode_use_rs, decode_use_rt  in  1  operand actually read
- decode_imm32  in  XLEN  immediate
- dprf_ra, dprf_rb  out  AW  regfile read addresses (= decode_rs/decode_rt, combinational)
- dprf_ra_val, dprf_rb_val  in  XLEN  combinational regfile read data
- byp_valid  in  NBYP  producer slot k will write byp_rd[k]
- byp_ready  in  NBYP  producer k's value is available this cycle
- byp_rd  in  NBYP*AW  packed destination indices
- byp_val  in  NBYP*XLEN  packed result values
- rr_valid  out  1  execute slot valid
- rr_pc, rr_op, rr_altop, rr_rd, rr_imm32  out  as decode  registered fields
- rr_rs_val, rr_rt_val  out  XLEN  registered resolved operands
- exec_stall, exec_flush  in  1  from execute
- rr_stall  out  1  decode must hold
- rr_flush  out  1  = exec_flush
- hz_count  out  32  saturating count of hazard-bubble cycles

## Operation
- Per operand: match[k] = byp_valid[k] && byp_rd[k]==idx && !(R0_ZERO && idx==0). Select the lowest k with a match; if none, use regfile data. If R0_ZERO && idx==0, the value is 0.
- Hazard: an operand with use_* set whose selected match k has byp_ready[k]==0. Unused operands never hazard.
- hz = decode_valid && hazard && !exec_flush.
- rr_stall = exec_stall || hz (combinational).
- Register update, by priority:
  - i_reset or exec_flush: all outputs 0, rr_valid=0.
  - exec_stall: hold all outputs.
  - hz: rr_valid<=0, other fields don't-care (hold).
  - Otherwise: capture decode fields, resolved operands, rr_valid<=decode_valid.
- hz_count increments on each cycle where hz && !exec_stall, saturates at 0xFFFFFFFF, and clears on reset only (not on flush).

## Timing
- Latency is 1 cycle from decode to rr outputs. Forwarding is same-cycle combinational from byp_* into the capture flop.
- Reset values: every rr_* output 0, rr_valid 0, hz_count 0. rr_stall follows inputs combinationally.
- Flush takes priority over stall and hazard. A flush in the same cycle as a hazard does not count.
- A stall holds the hazard state; forwarding is re-evaluated each cycle, so the stage releases on the first cycle the producer is ready.
- Both operands matching the same producer is legal; both get the same value.

## Structure
- cs3220_pkg holds the opcode/altop widths and the bubble encoding (op 0).
- Sub-module rr_operand_mux is instantiated twice. It takes idx, use, regfile value and byp_* and produces value and hazard. It is a priority encoder loop over NBYP.

## Test plan
- No hazards: decode r3/r4 with regfile 0x11/0x22 -> next cycle rr_rs_val=0x11, rr_rt_val=0x22, rr_valid=1.
- Forward priority: byp0 rd=3 val=0xA ready, byp1 rd=3 val=0xB ready, decode rs=3 -> rr_rs_val=0xA.
- Load-use: byp0 rd=5 ready=0, decode rs=5 use_rs=1 -> rr_stall=1, rr_valid=0, hz_count=1. Next cycle ready=1 val=0x77 -> rr_rs_val=0x77, rr_valid=1. Repeat with use_rs=0 -> no stall.
- R0: byp0 rd=0 ready=0 val=0x5, decode rs=0 -> no stall, rr_rs_val=0.
- Stall/flush: exec_stall=1 for 3 cycles -> outputs held. exec_flush concurrent with a hazard -> rr_valid=0, all fields 0, hz_count unchanged.
- Reset mid-stall with hz_count=7 -> all outputs 0 and hz_count=0 next cycle.
